apb_pwm_multi: RTL and testbench
================================

# apb_pwm_multi

Multi-channel APB PWM peripheral, the parametrised successor of the single-channel APB PWM. It provides `NUM_CH` independent PWM channels. Each channel has its own period, pulse and control registers. Period and pulse values are double-buffered and update glitch-free at period boundaries. A sticky period-end status vector drives one level interrupt. The block sits on the APB peripheral bus and drives PWM pins directly.

## Interface
- `DATA_WIDTH`, 32: APB address and data width.
- `NUM_CH`, 4: number of PWM channels, 1..16.
- `CNT_WIDTH`, 16: width of each channel counter and of PERIOD and PULSE (≤ `DATA_WIDTH`).
- `PCLK`  in  1: single clock. Everything is rising-edge.
- `PRESETn`  in  1: synchronous, active-low reset.
- `PADDR`  in  `DATA_WIDTH`: byte address.
- `PSEL`, `PENABLE`, `PWRITE`  in  1: APB control.
- `PWDATA`  in  `DATA_WIDTH`: write data.
- `PREADY`  out  1: tied to 1 (zero wait states).
- `PRDATA`  out  `DATA_WIDTH`: read data.
- `PSLAVEERR`  out  1: error response.
- `PWM`  out  `NUM_CH`: registered channel outputs.
- `IRQ`  out  1: level interrupt, `|(STATUS & IRQ_EN)`.

## Operation
- Register map, channel c, base c*0x10:
  - +0x0 PERIOD, RW.
  - +0x4 PULSE, RW.
  - +0x8 CTRL, RW. bit0 EN, bit1 POL; other bits read 0.
  - +0xC COUNT, RO: live counter.
- Global registers, base NUM_CH*0x10:
  - +0x0 STATUS, RW1C. bit c = channel c period end.
  - +0x4 IRQ_EN, RW.
- Unused upper bits of every register read 0.
- APB transfers:
  - A write commits on the access-phase edge (PSEL & PENABLE & PWRITE).
  - PRDATA is driven during the access phase when PSEL & PENABLE & !PWRITE; otherwise 0.
- Error, PSLAVEERR=1 in the access phase, raised for any of:
  - PADDR[1:0] != 0.
  - Address beyond NUM_CH*0x10+0x4.
  - Write to COUNT.
- On error: no register changes and PRDATA=0. PSLAVEERR is 0 outside the access phase.
- Double buffering: PERIOD and PULSE writes go to staging registers. Active copies (PER_A, PUL_A) load from staging:
  - every cycle while EN=0;
  - on the wrap edge while EN=1.
- Counter, EN=1 and PER_A>0:
  - cnt counts 0..PER_A-1, then wraps to 0.
  - Wrap edge: cnt == PER_A-1.
- Raw output: `raw = (cnt < PUL_A)`.
  - PUL_A=0 gives 0% duty.
  - PUL_A ≥ PER_A gives 100% duty.
- Output: `PWM[c] <= EN & (PER_A!=0) & raw ^ POL`, registered.
- EN=0: cnt is held at 0 and PWM[c] = POL (idle level).
- EN=1 with PER_A=0: cnt is held at 0, PWM[c] = POL, and no wrap occurs.
- STATUS[c] sets on each wrap edge of channel c.
  - A W1C of a bit on the same edge as its set: set wins.
- Clearing EN mid-period: cnt returns to 0 on the next edge with no partial pulse afterwards. Staging values load immediately.
- Write to CTRL with EN already 1: POL applies on the next edge. EN stays running and the counter is not reset.

## Timing
- Reset values: every register is 0, PWM=0, IRQ=0, PRDATA=0, PSLAVEERR=0, PREADY=1.
- Reset mid-operation behaves identically; staging and active copies are both cleared.
- APB: 2-cycle transfers (setup, access) with no wait states. A read returns the register value as of the start of the access cycle.
- Enable latency: EN is written at edge E, so cnt=0 during cycle E..E+1.
  - PWM first reflects the new state at edge E+1.
  - PWM leads-by-nothing and lags cnt by exactly 1 cycle.
- High time: PUL_A cycles. Period: PER_A cycles, exact and jitter-free.
- Staging update: a write at any point in period N takes effect in period N+1 (from the wrap edge). A write on the wrap edge itself takes effect in period N+2.
- STATUS bit visible one cycle after the wrap edge. IRQ is combinational from the STATUS/IRQ_EN registers.
- Channels are independent; simultaneous wraps set multiple STATUS bits on the same edge.

## Test plan
- Reset state: hold PRESETn=0 for 3 cycles, release -> all reads return 0, PWM=0, IRQ=0, PREADY=1.
- Basic PWM: ch0 PERIOD=10, PULSE=3, CTRL=1 -> PWM[0] high for 3 cycles, low for 7, repeating. First rise one cycle after the CTRL write edge. COUNT reads cycle 0..9.
- Glitch-free update:
  - While ch1 runs PERIOD=8, PULSE=4, write PULSE=6 and PERIOD=12 at cnt=2.
  - Required: the current period stays 4/8; the next period is exactly 6/12.
  - Repeat with the write landing on the wrap edge: the new values take effect one period later.
- Boundaries:
  - PULSE=0 -> constant 0.
  - PULSE=PERIOD=5 -> constant 1.
  - PERIOD=0 with EN=1 -> PWM=POL and no STATUS set.
  - POL=1 with PULSE=2, PERIOD=4 -> low 2, high 2.
- Interrupt and W1C:
  - IRQ_EN=0x3 with ch0 and ch1 running -> STATUS bits set at each wrap and IRQ=1.
  - Write 0x1 to STATUS -> bit0 clears and IRQ stays 1 from bit1.
  - W1C coinciding with a wrap -> bit remains 1.
- Errors:
  - Read at offset 0x2 -> PSLAVEERR=1, PRDATA=0.
  - Write to ch0 COUNT -> PSLAVEERR=1, counter unaffected.
  - Access at NUM_CH*0x10+0x8 -> PSLAVEERR=1.
  - All registers unchanged after each case.

Source files
------------

// File: rtl/apb_pwm_multi_if.sv
// APB slave bus bundle for the multi-channel PWM peripheral.
// The slave modport is the peripheral side; the master modport is the bus side.
interface apb_pwm_multi_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLAVEERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLAVEERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLAVEERR
  );

endinterface

// File: rtl/apb_pwm_multi.sv
// Multi-channel APB PWM: per-channel double-buffered period/pulse, registered outputs,
// sticky period-end status with a single level interrupt.
module apb_pwm_multi #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_pwm_multi_if.slave    apb,
  output logic [NUM_CH-1:0] PWM,
  output logic              IRQ
);

  localparam int unsigned           BlkW      = DATA_WIDTH - 4;
  localparam logic [DATA_WIDTH-1:0] AddrLimit = DATA_WIDTH'(NUM_CH * 16 + 8);
  localparam logic [BlkW-1:0]       GlobBlk   = BlkW'(NUM_CH);

  // Bus decode
  logic [BlkW-1:0] blk;
  logic [1:0]      off;
  logic            access;
  logic            err;
  logic            wr_ok;
  logic            rd_ok;

  assign blk = apb.PADDR[DATA_WIDTH-1:4];
  assign off = apb.PADDR[3:2];

  always_comb begin
    access = apb.PSEL & apb.PENABLE;
    err    = access & ((apb.PADDR[1:0] != 2'b00) |
                       (apb.PADDR >= AddrLimit) |
                       (apb.PWRITE & (blk < GlobBlk) & (off == 2'd3)));
    wr_ok  = access & apb.PWRITE & ~err;
    rd_ok  = access & ~apb.PWRITE & ~err;
  end

  // Channel state
  logic [CNT_WIDTH-1:0] per_s_q [NUM_CH];
  logic [CNT_WIDTH-1:0] per_s_d [NUM_CH];
  logic [CNT_WIDTH-1:0] pul_s_q [NUM_CH];
  logic [CNT_WIDTH-1:0] pul_s_d [NUM_CH];
  logic [CNT_WIDTH-1:0] per_a_q [NUM_CH];
  logic [CNT_WIDTH-1:0] per_a_d [NUM_CH];
  logic [CNT_WIDTH-1:0] pul_a_q [NUM_CH];
  logic [CNT_WIDTH-1:0] pul_a_d [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pol_q, pol_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] ch_wr;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_wr[c] = wr_ok & (blk == BlkW'(c));
      run[c]   = en_q[c] & (per_a_q[c] != '0);
      wrap[c]  = run[c] & (cnt_q[c] == per_a_q[c] - 1'b1);
      // Active copies track staging while idle, and swap only at a period boundary when running
      load[c]  = ~en_q[c] | wrap[c];

      cnt_d[c]   = (run[c] & ~wrap[c]) ? cnt_q[c] + 1'b1 : '0;
      per_a_d[c] = load[c] ? per_s_q[c] : per_a_q[c];
      pul_a_d[c] = load[c] ? pul_s_q[c] : pul_a_q[c];
      pwm_d[c]   = (run[c] & (cnt_q[c] < pul_a_q[c])) ^ pol_q[c];

      per_s_d[c] = per_s_q[c];
      pul_s_d[c] = pul_s_q[c];
      en_d[c]    = en_q[c];
      pol_d[c]   = pol_q[c];
      if (ch_wr[c]) begin
        unique case (off)
          2'd0: per_s_d[c] = apb.PWDATA[CNT_WIDTH-1:0];
          2'd1: pul_s_d[c] = apb.PWDATA[CNT_WIDTH-1:0];
          2'd2: begin
            en_d[c]  = apb.PWDATA[0];
            pol_d[c] = apb.PWDATA[1];
          end
          default: ;
        endcase
      end
    end
  end

  // Global registers; a wrap on the same edge as a W1C keeps the bit set
  always_comb begin
    status_d = status_q;
    irq_en_d = irq_en_q;
    if (wr_ok && (blk == GlobBlk)) begin
      if (off == 2'd0) status_d = status_q & ~apb.PWDATA[NUM_CH-1:0];
      if (off == 2'd1) irq_en_d = apb.PWDATA[NUM_CH-1:0];
    end
    status_d = status_d | wrap;
  end

  // Read mux reflects register state at the start of the access cycle
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      if (blk == GlobBlk) begin
        if (off == 2'd0) rdata = DATA_WIDTH'(status_q);
        if (off == 2'd1) rdata = DATA_WIDTH'(irq_en_q);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (blk == BlkW'(c)) begin
            unique case (off)
              2'd0: rdata = DATA_WIDTH'(per_s_q[c]);
              2'd1: rdata = DATA_WIDTH'(pul_s_q[c]);
              2'd2: rdata = DATA_WIDTH'({pol_q[c], en_q[c]});
              2'd3: rdata = DATA_WIDTH'(cnt_q[c]);
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        per_s_q[c] <= '0;
        pul_s_q[c] <= '0;
        per_a_q[c] <= '0;
        pul_a_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      en_q     <= '0;
      pol_q    <= '0;
      pwm_q    <= '0;
      status_q <= '0;
      irq_en_q <= '0;
    end else begin
      per_s_q  <= per_s_d;
      pul_s_q  <= pul_s_d;
      per_a_q  <= per_a_d;
      pul_a_q  <= pul_a_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      pol_q    <= pol_d;
      pwm_q    <= pwm_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign apb.PREADY    = 1'b1;
  assign apb.PRDATA    = rdata;
  assign apb.PSLAVEERR = err;
  assign PWM           = pwm_q;
  assign IRQ           = |(status_q & irq_en_q);

endmodule

// File: tb/tb_apb_pwm_multi.sv
// Randomised and directed bench for apb_pwm_multi against a timestamp-based channel model.
module tb_apb_pwm_multi;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int GLOB = NCH * 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  apb_pwm_multi_if #(.DATA_WIDTH(DW)) bus ();
  logic [NCH-1:0] pwm;
  logic           irq;

  apb_pwm_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
    .PCLK   (clk),
    .PRESETn(rstn),
    .apb    (bus),
    .PWM    (pwm),
    .IRQ    (irq)
  );

  // Model: each channel remembers the edge at which its current period began
  int           m_per_s [NCH], m_pul_s [NCH], m_per_a [NCH], m_pul_a [NCH], m_start [NCH];
  bit           m_en [NCH], m_pol [NCH];
  bit [NCH-1:0] m_status, m_irq_en, m_pwm;
  int           edges;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input bit w);
    return (a[1:0] != 2'b00) || (a > GLOB + 4) || (w && (a < GLOB) && (a[3:0] == 4'hC));
  endfunction

  function automatic int m_count(input int c);
    return (m_en[c] && m_per_a[c] != 0) ? edges - m_start[c] : 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int c;
    if (m_err(a, 1'b0)) return 32'd0;
    if (a >= GLOB) return (a[3:0] == 4'h0) ? 32'(m_status) : 32'(m_irq_en);
    c = int'(a[7:4]);
    case (a[3:2])
      2'd0:    return 32'(m_per_s[c]);
      2'd1:    return 32'(m_pul_s[c]);
      2'd2:    return {30'd0, m_pol[c], m_en[c]};
      default: return 32'(m_count(c));
    endcase
  endfunction

  task automatic model_edge();
    bit [NCH-1:0] wraps;
    wraps = '0;
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        m_per_s[c] = 0; m_pul_s[c] = 0; m_per_a[c] = 0; m_pul_a[c] = 0;
        m_en[c] = 0; m_pol[c] = 0; m_start[c] = edges + 1;
      end
      m_status = '0; m_irq_en = '0; m_pwm = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit run, wrap;
        int pos;
        run  = m_en[c] && (m_per_a[c] != 0);
        pos  = edges - m_start[c];
        wrap = run && (pos == m_per_a[c] - 1);
        m_pwm[c] = (run && (pos < m_pul_a[c])) ^ m_pol[c];
        if (!m_en[c] || wrap) begin
          m_per_a[c] = m_per_s[c];
          m_pul_a[c] = m_pul_s[c];
        end
        if (!run || wrap) m_start[c] = edges + 1;
        wraps[c] = wrap;
      end
      if (bus.PSEL && bus.PENABLE && bus.PWRITE && !m_err(bus.PADDR, 1'b1)) begin
        if (bus.PADDR >= GLOB) begin
          if (bus.PADDR[3:0] == 4'h0) m_status = m_status & ~bus.PWDATA[NCH-1:0];
          else                        m_irq_en = bus.PWDATA[NCH-1:0];
        end else begin
          case (bus.PADDR[3:2])
            2'd0: m_per_s[bus.PADDR[7:4]] = int'(bus.PWDATA[CW-1:0]);
            2'd1: m_pul_s[bus.PADDR[7:4]] = int'(bus.PWDATA[CW-1:0]);
            2'd2: begin
              m_en[bus.PADDR[7:4]]  = bus.PWDATA[0];
              m_pol[bus.PADDR[7:4]] = bus.PWDATA[1];
            end
            default: ;
          endcase
        end
      end
      m_status = m_status | wraps;
    end
    edges++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pwm", 32'(pwm), 32'(m_pwm));
    check("irq", 32'(irq), 32'(|(m_status & m_irq_en)));
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    tick();
    bus.PENABLE = 1'b1;
    #1;
    check("wr_err", 32'(bus.PSLAVEERR), 32'(m_err(a, 1'b1)));
    tick();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    tick();
    check("setup_err", 32'(bus.PSLAVEERR), 32'd0);
    bus.PENABLE = 1'b1;
    #1;
    d = bus.PRDATA;
    e = bus.PSLAVEERR;
    check("rd_data", d, m_read(a));
    check("rd_err", 32'(e), 32'(m_err(a, 1'b0)));
    check("pready", 32'(bus.PREADY), 32'd1);
    tick();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic count_high(input int c, input int n, output int h);
    h = 0;
    repeat (n) begin
      tick();
      h += int'(pwm[c]);
    end
  endtask

  // Advance until channel c is at position tgt within its period
  task automatic align(input int c, input int tgt);
    int k;
    for (k = 0; k < 64; k++) begin
      if (m_count(c) == tgt) break;
      tick();
    end
    if (k == 64) check("align_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_all(input bit expect_zero);
    logic [31:0] d;
    logic        e;
    for (int a = 0; a <= GLOB + 4; a += 4) begin
      apb_read(32'(a), d, e);
      if (expect_zero) check("reset_rd", d, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          h;

    bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    edges = 0;
    for (int c = 0; c < NCH; c++) m_start[c] = 0;

    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    read_all(1'b1);

    // ch0 10/3: first rise one cycle after the CTRL write edge, 3 high per 10
    apb_write(32'h00, 32'd10);
    apb_write(32'h04, 32'd3);
    apb_write(32'h08, 32'd1);
    tick();
    check("first_rise", 32'(pwm[0]), 32'd1);
    count_high(0, 19, h);
    check("ch0_duty", 32'(h), 32'd5);
    for (int i = 0; i < 4; i++) apb_read(32'h0C, d, e);

    // ch1 8/4, retarget to 6/12 mid-period and at a wrap edge
    apb_write(32'h10, 32'd8);
    apb_write(32'h14, 32'd4);
    apb_write(32'h18, 32'd1);
    idle(9);
    align(1, 1);
    apb_write(32'h14, 32'd6);
    apb_write(32'h10, 32'd12);
    idle(30);
    count_high(1, 12, h);
    check("ch1_new_duty", 32'(h), 32'd6);
    align(1, 10);
    apb_write(32'h14, 32'd2);
    idle(30);
    count_high(1, 12, h);
    check("ch1_wrap_duty", 32'(h), 32'd2);

    // Boundaries on ch2/ch3
    apb_write(32'h20, 32'd5);
    apb_write(32'h28, 32'd1);
    count_high(2, 10, h);
    check("pulse0", 32'(h), 32'd0);
    apb_write(32'h24, 32'd5);
    idle(6);
    count_high(2, 10, h);
    check("pulse_eq_per", 32'(h), 32'd10);
    apb_write(32'h28, 32'd0);
    apb_write(32'h20, 32'd0);
    apb_write(32'h28, 32'd3);
    apb_write(GLOB, 32'h4);
    idle(20);
    check("per0_pwm", 32'(pwm[2]), 32'd1);
    apb_read(GLOB, d, e);
    check("per0_status", 32'(d[2]), 32'd0);
    apb_write(32'h30, 32'd4);
    apb_write(32'h34, 32'd2);
    apb_write(32'h38, 32'd3);
    idle(3);
    count_high(3, 8, h);
    check("pol_duty", 32'(h), 32'd4);

    // Interrupt and W1C
    apb_write(GLOB + 4, 32'h3);
    idle(15);
    check("irq_on", 32'(irq), 32'd1);
    apb_write(GLOB, 32'h1);
    check("irq_bit1", 32'(irq), 32'd1);
    idle(12);
    align(0, 8);
    apb_write(GLOB, 32'h1);
    apb_read(GLOB, d, e);
    check("w1c_vs_wrap", 32'(d[0]), 32'd1);

    // Error responses leave every register untouched
    apb_read(32'h02, d, e);
    check("misalign_err", 32'(e), 32'd1);
    check("misalign_data", d, 32'd0);
    apb_write(32'h0C, 32'hFFFF);
    apb_write(32'(GLOB + 8), 32'hFFFF_FFFF);
    apb_read(32'(GLOB + 8), d, e);
    check("range_err", 32'(e), 32'd1);
    read_all(1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned k, c;
      logic [31:0] hi;
      k  = $urandom_range(0, 9);
      c  = $urandom_range(0, NCH - 1);
      hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_0000) : 32'd0;
      case (k)
        0, 1: apb_write(32'(c * 16),     hi | 32'($urandom_range(0, 12)));
        2:    apb_write(32'(c * 16 + 4), hi | 32'($urandom_range(0, 14)));
        3:    apb_write(32'(c * 16 + 8), $urandom_range(0, 7));
        4:    apb_write(GLOB, $urandom);
        5:    apb_write(GLOB + 4, $urandom);
        6, 7: apb_read(32'($urandom_range(0, (GLOB + 4) / 4) * 4), d, e);
        8: begin
          if ($urandom_range(0, 1) == 1) apb_read(32'($urandom_range(0, GLOB + 12)), d, e);
          else apb_write(32'($urandom_range(0, GLOB + 12)), $urandom);
        end
        default: idle($urandom_range(0, 6));
      endcase
    end

    // Reset in the middle of activity
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    check("rst2_pwm", 32'(pwm), 32'd0);
    read_all(1'b1);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
